fft_out_reorder: RTL and testbench

- Output stage directly downstream of the 4-lane radix-2^2 FFT core.
- Captures the core's four parallel bit-reversed-order output lanes into a ping-pong RAM.
- Emits each N-point frame in natural bin order, 4 bins per beat, with a valid/ready handshake toward the consumer.

---
 rtl/fft_out_reorder.sv | 209 ++++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// Reorders the 4-lane bit-reversed FFT output into natural bin order through a ping-pong store.
// Define FFT_OUT_REORDER_OVFCNT_EN to add the saturating dropped-frame counter o_ovf_cnt.
module fft_out_reorder #(
  parameter int NBITS_out = 15,
  parameter int N         = 128,
  parameter int LOGN      = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [2*NBITS_out-1:0] i_lane0,
  input  logic [2*NBITS_out-1:0] i_lane1,
  input  logic [2*NBITS_out-1:0] i_lane2,
  input  logic [2*NBITS_out-1:0] i_lane3,
  input  logic                   i_ready,
  output logic [2*NBITS_out-1:0] o_bin0,
  output logic [2*NBITS_out-1:0] o_bin1,
  output logic [2*NBITS_out-1:0] o_bin2,
  output logic [2*NBITS_out-1:0] o_bin3,
  output logic                   o_valid,
  output logic                   o_sof,
  output logic                   o_eof,
  output logic                   o_ovf
`ifdef FFT_OUT_REORDER_OVFCNT_EN
  ,
  output logic [7:0]             o_ovf_cnt
`endif
);

  localparam int W     = 2 * NBITS_out;
  localparam int KW    = LOGN - 2;
  localparam int DEPTH = 2 * (N / 4);
  localparam logic [KW-1:0] LAST = {KW{1'b1}};

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k;
  logic          wbank;
  logic          drop_r;
  logic          drop_now;
  logic          wr_en;
  logic          frame_drop;
  logic [1:0]    full;
  logic [1:0]    set_mask;
  logic [1:0]    clr_mask;
  logic          rbank;
  logic [KW-1:0] beat;
  logic [KW-1:0] rd_beat;
  logic          load;
  logic          free_bank;

  logic [W-1:0]    lane  [4];
  logic [LOGN-1:0] wbin  [4];
  logic [W-1:0]    wdata [4];
  logic [KW-1:0]   waddr [4];
  logic [W-1:0]    rdata [4];
  logic [W-1:0]    mem   [4][DEPTH];

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = x[LOGN-1-i];
    return r;
  endfunction

  // Bins sharing their top two bits land in different sub-memories, and so do bins
  // sharing their low two bits, so both the write and the read touch each memory once.
  function automatic logic [1:0] mem_sel(input logic [1:0] top, input logic [1:0] low);
    return top + low;
  endfunction

  always_comb begin
    lane[0] = i_lane0;
    lane[1] = i_lane1;
    lane[2] = i_lane2;
    lane[3] = i_lane3;
  end

  // A frame's drop decision is taken on its first cycle and held for the rest of it.
  assign drop_now   = (k == '0) ? full[wbank] : drop_r;
  assign wr_en      = i_enable && !drop_now;
  assign frame_drop = i_enable && (k == '0) && full[wbank];

  always_comb begin
    set_mask = 2'b00;
    if (wr_en && (k == LAST)) set_mask[wbank] = 1'b1;
  end

  always_comb begin
    clr_mask = 2'b00;
    if (free_bank) clr_mask[rbank] = 1'b1;
  end

  always_comb begin
    for (int l = 0; l < 4; l++) wbin[l] = bitrev({k, 2'(l)});
  end

  always_comb begin
    for (int m = 0; m < 4; m++) begin
      wdata[m] = '0;
      waddr[m] = '0;
    end
    for (int l = 0; l < 4; l++) begin
      wdata[mem_sel(wbin[l][LOGN-1 -: 2], wbin[l][1:0])] = lane[l];
      waddr[mem_sel(wbin[l][LOGN-1 -: 2], wbin[l][1:0])] = wbin[l][LOGN-1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int m = 0; m < 4; m++) mem[m][{wbank, waddr[m]}] <= wdata[m];
    end
  end

  // Write side: frame position, bank pointer and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      wbank  <= 1'b0;
      drop_r <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (i_enable) begin
      k      <= k + KW'(1);
      drop_r <= drop_now;
      if (frame_drop) o_ovf <= 1'b1;
      if ((k == LAST) && !drop_now) wbank <= ~wbank;
    end else begin
      k <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) full <= 2'b00;
    else      full <= (full | set_mask) & ~clr_mask;
  end

`ifdef FFT_OUT_REORDER_OVFCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 o_ovf_cnt <= 8'd0;
    else if (frame_drop && o_ovf_cnt != 8'hFF) o_ovf_cnt <= o_ovf_cnt + 8'd1;
  end
`endif

  // Read side: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    free_bank = 1'b0;
    rd_beat   = beat + KW'(1);
    case (state)
      IDLE: if (full[rbank]) state_nxt = LOAD;
      LOAD: begin
        load      = 1'b1;
        rd_beat   = '0;
        state_nxt = SEND;
      end
      SEND: if (o_valid && i_ready) begin
        if (beat == LAST) begin
          free_bank = 1'b1;
          // A bank completing on this same edge still counts as ready to send.
          state_nxt = (full[~rbank] || set_mask[~rbank]) ? LOAD : IDLE;
        end else begin
          load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int m = 0; m < 4; m++)
      rdata[m] = mem[mem_sel(rd_beat[KW-1 -: 2], 2'(m))][{rbank, rd_beat}];
  end

  // Read side: registered output beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_bin0  <= '0;
      o_bin1  <= '0;
      o_bin2  <= '0;
      o_bin3  <= '0;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
      beat    <= '0;
      rbank   <= 1'b0;
    end else if (load) begin
      o_bin0  <= rdata[0];
      o_bin1  <= rdata[1];
      o_bin2  <= rdata[2];
      o_bin3  <= rdata[3];
      o_valid <= 1'b1;
      o_sof   <= (rd_beat == '0);
      o_eof   <= (rd_beat == LAST);
      beat    <= rd_beat;
    end else if (free_bank) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
      rbank   <= ~rbank;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder at N=16: directed tables plus a frame-level scoreboard
// driven by randomized enable/ready/data traffic.
module tb_fft_out_reorder;

  localparam int NBITS = 15;
  localparam int NN    = 16;
  localparam int LOGN  = 4;
  localparam int W     = 2 * NBITS;
  localparam int NBEAT = NN / 4;

  typedef logic [NN-1:0][W-1:0] frame_t;
  typedef struct { int r0; int r1; int r2; int r3; bit sof; bit eof; } beat_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_enable = 1'b0;
  logic i_ready = 1'b0;
  logic [W-1:0] i_lane0 = '0, i_lane1 = '0, i_lane2 = '0, i_lane3 = '0;
  logic [W-1:0] o_bin0, o_bin1, o_bin2, o_bin3;
  logic o_valid, o_sof, o_eof, o_ovf;
`ifdef FFT_OUT_REORDER_OVFCNT_EN
  logic [7:0] o_ovf_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fft_out_reorder #(.NBITS_out(NBITS), .N(NN), .LOGN(LOGN)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_lane0(i_lane0), .i_lane1(i_lane1), .i_lane2(i_lane2), .i_lane3(i_lane3),
    .i_ready(i_ready),
    .o_bin0(o_bin0), .o_bin1(o_bin1), .o_bin2(o_bin2), .o_bin3(o_bin3),
    .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof), .o_ovf(o_ovf)
`ifdef FFT_OUT_REORDER_OVFCNT_EN
    , .o_ovf_cnt(o_ovf_cnt)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < LOGN; i++) if (x[i]) r |= (1 << (LOGN - 1 - i));
    return r;
  endfunction

  function automatic logic [W-1:0] sample(input int base, input int j, input bit zimag);
    logic [NBITS-1:0] re, im;
    re = NBITS'(base + j);
    im = zimag ? '0 : NBITS'(base * 7 + j * 3 + 1);
    return {re, im};
  endfunction

  // Frame-level reference: each completed frame is a bin-indexed array queued for output;
  // a frame starting while two frames are still unread is dropped.
  frame_t exp_q[$];
  frame_t cur = '0;
  int m_k = 0, m_beat = 0, m_occ = 0, m_drops = 0, frames_out = 0;
  bit m_ovf = 1'b0, m_drop = 1'b0;

  task automatic model_step();
    frame_t f;
    if (!rst) begin
      exp_q.delete();
      m_k = 0; m_beat = 0; m_occ = 0; m_drops = 0; m_ovf = 1'b0; m_drop = 1'b0;
      return;
    end
    chk("ovf_flag", W'(o_ovf), W'(m_ovf));
`ifdef FFT_OUT_REORDER_OVFCNT_EN
    chk("ovf_cnt", W'(o_ovf_cnt), W'((m_drops > 255) ? 255 : m_drops));
`endif
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", W'(o_valid), '0);
      end else begin
        f = exp_q[0];
        chk("sb_bin0", o_bin0, f[4*m_beat+0]);
        chk("sb_bin1", o_bin1, f[4*m_beat+1]);
        chk("sb_bin2", o_bin2, f[4*m_beat+2]);
        chk("sb_bin3", o_bin3, f[4*m_beat+3]);
        chk("sb_sof", W'(o_sof), W'(m_beat == 0));
        chk("sb_eof", W'(o_eof), W'(m_beat == NBEAT - 1));
      end
    end
    if (i_enable) begin
      if (m_k == 0) begin
        m_drop = (m_occ == 2);
        if (m_drop) begin m_ovf = 1'b1; m_drops++; end
      end
      if (!m_drop) begin
        cur[brev(4*m_k+0)] = i_lane0;
        cur[brev(4*m_k+1)] = i_lane1;
        cur[brev(4*m_k+2)] = i_lane2;
        cur[brev(4*m_k+3)] = i_lane3;
        if (m_k == NBEAT - 1) begin exp_q.push_back(cur); m_occ++; end
      end
      m_k = (m_k + 1) % NBEAT;
    end else begin
      m_k = 0;
    end
    if (o_valid && i_ready && exp_q.size() > 0) begin
      if (m_beat == NBEAT - 1) begin
        void'(exp_q.pop_front());
        m_occ--; frames_out++; m_beat = 0;
      end else begin
        m_beat++;
      end
    end
  endtask

  logic         vlog [2048];
  logic         sof_log [2048];
  logic         eof_log [2048];
  logic [W-1:0] blog [2048][4];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    vlog[cyc & 2047] = o_valid;
    sof_log[cyc & 2047] = o_sof;
    eof_log[cyc & 2047] = o_eof;
    blog[cyc & 2047][0] = o_bin0;
    blog[cyc & 2047][1] = o_bin1;
    blog[cyc & 2047][2] = o_bin2;
    blog[cyc & 2047][3] = o_bin3;
    model_step();
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input int ncyc, input bit zimag);
    for (int kk = 0; kk < ncyc; kk++) begin
      i_enable = 1'b1;
      i_lane0 = sample(base, 4*kk+0, zimag);
      i_lane1 = sample(base, 4*kk+1, zimag);
      i_lane2 = sample(base, 4*kk+2, zimag);
      i_lane3 = sample(base, 4*kk+3, zimag);
      step();
    end
  endtask

  beat_vec_t tv[4];
  bit pat2[11];
  int c0, fo, idx;
  logic pv, pr;
  logic [W-1:0] pb0, pb3;
  logic [W-1:0] tmp;

  initial begin
    tv[0] = '{0, 8, 4, 12, 1'b1, 1'b0};
    tv[1] = '{2, 10, 6, 14, 1'b0, 1'b0};
    tv[2] = '{1, 9, 5, 13, 1'b0, 1'b0};
    tv[3] = '{3, 11, 7, 15, 1'b0, 1'b1};
    pat2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", W'(o_valid), '0);
    chk("rst_sof", W'(o_sof), '0);
    chk("rst_eof", W'(o_eof), '0);
    chk("rst_ovf", W'(o_ovf), '0);
    chk("rst_bin0", o_bin0, '0);
    chk("rst_bin3", o_bin3, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    i_ready = 1'b1;
    step(); step();

    // Single frame: bin order, sof/eof, two-edge latency
    c0 = cyc;
    send_frame(0, 4, 1'b1);
    i_enable = 1'b0;
    repeat (8) step();
    chk("t1_lat_e0", W'(vlog[(c0+4) & 2047]), '0);
    chk("t1_lat_e1", W'(vlog[(c0+5) & 2047]), '0);
    for (int b = 0; b < 4; b++) begin
      idx = (c0 + 6 + b) & 2047;
      chk("t1_valid", W'(vlog[idx]), W'(1));
      tmp = blog[idx][0]; chk("t1_re0", W'(tmp[W-1:NBITS]), W'(tv[b].r0));
      tmp = blog[idx][1]; chk("t1_re1", W'(tmp[W-1:NBITS]), W'(tv[b].r1));
      tmp = blog[idx][2]; chk("t1_re2", W'(tmp[W-1:NBITS]), W'(tv[b].r2));
      tmp = blog[idx][3]; chk("t1_re3", W'(tmp[W-1:NBITS]), W'(tv[b].r3));
      chk("t1_sof", W'(sof_log[idx]), W'(tv[b].sof));
      chk("t1_eof", W'(eof_log[idx]), W'(tv[b].eof));
    end
    chk("t1_after", W'(vlog[(c0+10) & 2047]), '0);

    // Back-to-back frames: exactly one idle beat between them
    c0 = cyc;
    send_frame(0, 4, 1'b0);
    send_frame(16, 4, 1'b0);
    i_enable = 1'b0;
    repeat (14) step();
    for (int i = 0; i < 11; i++)
      chk("t2_valid_pattern", W'(vlog[(c0+5+i) & 2047]), W'(pat2[i]));
    chk("t2_ovf", W'(o_ovf), '0);
    chk("t2_drained", W'(exp_q.size()), '0);

    // Stalled consumer: third frame dropped, first two delivered on release
    fo = frames_out;
    i_ready = 1'b0;
    send_frame(100, 4, 1'b0);
    send_frame(200, 4, 1'b0);
    send_frame(300, 4, 1'b0);
    i_enable = 1'b0;
    @(negedge clk);
    chk("t3_ovf", W'(o_ovf), W'(1));
`ifdef FFT_OUT_REORDER_OVFCNT_EN
    chk("t3_ovf_cnt", W'(o_ovf_cnt), W'(1));
`endif
    chk("t3_held", W'(o_valid), W'(1));
    chk("t3_sof_held", W'(o_sof), W'(1));
    @(posedge clk); #1;
    i_ready = 1'b1;
    repeat (14) step();
    chk("t3_frames_out", W'(frames_out - fo), W'(2));
    chk("t3_drained", W'(exp_q.size()), '0);

    // Toggling ready: beats hold while not accepted
    send_frame(40, 4, 1'b0);
    i_enable = 1'b0;
    pv = 1'b0; pr = 1'b1; pb0 = '0; pb3 = '0;
    for (int i = 0; i < 16; i++) begin
      i_ready = (i % 2 == 0);
      @(negedge clk);
      if (pv && !pr) begin
        chk("t4_hold_valid", W'(o_valid), W'(1));
        chk("t4_hold_bin0", o_bin0, pb0);
        chk("t4_hold_bin3", o_bin3, pb3);
      end
      pv = o_valid; pr = i_ready; pb0 = o_bin0; pb3 = o_bin3;
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    repeat (6) step();
    chk("t4_drained", W'(exp_q.size()), '0);

    // Aborted partial frame followed by a complete one
    fo = frames_out;
    send_frame(400, 2, 1'b0);
    i_enable = 1'b0;
    step();
    send_frame(500, 4, 1'b0);
    i_enable = 1'b0;
    repeat (12) step();
    chk("t5_frames_out", W'(frames_out - fo), W'(1));
    chk("t5_drained", W'(exp_q.size()), '0);

    // Asynchronous reset during SEND clears outputs and the sticky flag at once
    i_ready = 1'b0;
    send_frame(600, 4, 1'b0);
    i_enable = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("t6_pre_valid", W'(o_valid), W'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6_valid", W'(o_valid), '0);
    chk("t6_sof", W'(o_sof), '0);
    chk("t6_eof", W'(o_eof), '0);
    chk("t6_ovf", W'(o_ovf), '0);
    chk("t6_bin0", o_bin0, '0);
    chk("t6_bin1", o_bin1, '0);
    chk("t6_bin2", o_bin2, '0);
    chk("t6_bin3", o_bin3, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    i_ready = 1'b1;
    step();
    fo = frames_out;
    send_frame(700, 4, 1'b0);
    i_enable = 1'b0;
    repeat (10) step();
    chk("t6_post_ovf", W'(o_ovf), '0);
    chk("t6_frames_out", W'(frames_out - fo), W'(1));
    chk("t6_drained", W'(exp_q.size()), '0);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      i_enable = ($urandom_range(0, 15) != 0);
      i_lane0 = W'($urandom);
      i_lane1 = W'($urandom);
      i_lane2 = W'($urandom);
      i_lane3 = W'($urandom);
      i_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    i_enable = 1'b0;
    i_ready = 1'b1;
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) step();
    chk("rand_drained", W'(exp_q.size()), '0);
    step();
    @(negedge clk);
    chk("rand_idle", W'(o_valid), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
